// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud/width defaults and counter sizing helpers.
// Defaults fall back to 8 bits at 50 MHz / 115200 baud when the board config macros are absent.
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 115200
`endif

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    localparam int DATA_WIDTH     = `WIDTH;
    localparam int CLOCKS_PER_BIT = `CLK_FREQ / `BAUD_RATE;
    localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;

    function automatic int baud_cnt_width(input int clocks_per_bit);
        return $clog2(clocks_per_bit);
    endfunction

    function automatic int bit_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; both flops reset to RESET_VALUE.
module uart_sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sync.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at mid-bit, strobes valid or frame_error.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (decisions one cycle later).
module uart_rx_sync #(
    parameter int WIDTH          = uart_pkg::DATA_WIDTH,
    parameter int CLOCKS_PER_BIT = uart_pkg::CLOCKS_PER_BIT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_error,
    output logic             busy
);

    import uart_pkg::*;

    localparam int CW = baud_cnt_width(CLOCKS_PER_BIT);
    localparam int BW = bit_cnt_width(WIDTH);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    uart_state_e      state, state_n;
    logic [CW-1:0]    baud_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             rx_s, rx_hist, fall;
    logic             cnt_zero, sampling;
    logic             sample_tick, sample_bit;
    logic             load_half, do_shift, take_data, take_err;

    uart_sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset) rx_hist <= 1'b1;
        else       rx_hist <= rx_s;
    end

    assign fall     = rx_hist & ~rx_s;
    assign cnt_zero = (baud_cnt == '0);
    assign sampling = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
    assign busy     = (state != ST_IDLE);

`ifdef UART_RX_MAJORITY_EN
    // Votes at counter 1 and 0 are held; the third is the live line one cycle after reload.
    logic maj_a, maj_b, maj_pend;

    always_ff @(posedge clock) begin
        if (reset) begin
            maj_a    <= 1'b1;
            maj_b    <= 1'b1;
            maj_pend <= 1'b0;
        end else begin
            if (baud_cnt == CNT_ONE) maj_a <= rx_s;
            if (cnt_zero)            maj_b <= rx_s;
            maj_pend <= sampling && cnt_zero;
        end
    end

    assign sample_tick = maj_pend;
    assign sample_bit  = (maj_a & maj_b) | (maj_a & rx_s) | (maj_b & rx_s);
`else
    assign sample_tick = sampling && cnt_zero;
    assign sample_bit  = rx_s;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load_half = 1'b0;
        do_shift  = 1'b0;
        take_data = 1'b0;
        take_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_n   = ST_START;
                    load_half = 1'b1;
                end
            end
            ST_START: begin
                if (sample_tick) state_n = sample_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (sample_tick) begin
                    do_shift = 1'b1;
                    if (bit_cnt == LAST_BIT) state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    if (sample_bit) begin
                        take_data = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        take_err  = 1'b1;
                        state_n   = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // valid is a bare strobe with no ready: the consumer must capture data in the cycle valid is high.
    // The baud counter free-runs with period CLOCKS_PER_BIT once a frame starts, so every
    // state entry after START lands on a fresh reload.
    always_ff @(posedge clock) begin
        if (reset) begin
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            valid       <= take_data;
            frame_error <= take_err;
            if (load_half)     baud_cnt <= HALF_LOAD;
            else if (sampling) baud_cnt <= cnt_zero ? FULL_LOAD : baud_cnt - CNT_ONE;
            if (load_half)     bit_cnt <= '0;
            else if (do_shift) bit_cnt <= bit_cnt + BIT_ONE;
            if (do_shift)  shift_reg <= {sample_bit, shift_reg[WIDTH-1:1]};
            if (take_data) data      <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx_sync.sv
// Self-checking bench for uart_rx_sync: frame-level model with an expected-event queue and a
// per-cycle compare process, plus directed literal checks. Honours UART_RX_MAJORITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_sync;

  localparam int W      = 8;
  localparam int CPB    = 16;
  localparam int T      = 10;
  localparam realtime BIT_NS  = 160.0;
  localparam realtime FAST_NS = 153.6;
  localparam realtime SLOW_NS = 166.4;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 3 + 8 + 144 + 1 + 1;
  localparam int LAT_LITERAL = 157;
  localparam int GLITCH_DONE = 12;
`else
  localparam int LAT = 3 + 8 + 144 + 1;
  localparam int LAT_LITERAL = 156;
  localparam int GLITCH_DONE = 12;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic [W-1:0] data;
  logic valid, frame_error, busy;

  always #(T/2) clock = ~clock;

  uart_rx_sync #(.WIDTH(W), .CLOCKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .valid       (valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  bit           exp_err_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] model_data = '0;
  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int last_strobe_edge = 0;
  logic rst_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: good stop bit -> byte strobed on valid; low stop bit -> frame_error, data kept.
  // Strobe is visible in the cycle before consumer edge (fall + LAT).
  task automatic expect_frame(input logic [W-1:0] b, input bit stop_bit, input int t0);
    exp_q.push_back(b);
    exp_err_q.push_back(!stop_bit);
    exp_cyc_q.push_back(t0 + LAT - 1);
  endtask

  always @(posedge clock) rst_seen <= reset;

  // compare process
  always @(negedge clock) begin
    logic [W-1:0] b;
    bit is_err;
    if (rst_seen === 1'b1) model_data = '0;
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      b = exp_q.pop_front();
      is_err = exp_err_q.pop_front();
      void'(exp_cyc_q.pop_front());
      if (!is_err) begin
        check("strobe_valid", {valid, frame_error}, 2'b10);
        model_data = b;
      end else begin
        check("strobe_ferr", {valid, frame_error}, 2'b01);
      end
    end else begin
      check("no_strobe", {valid, frame_error}, 2'b00);
    end
    check("data_hold", data, model_data);
    if (valid === 1'b1) begin
      n_valid++;
      last_strobe_edge = cyc + 1;
    end
    if (frame_error === 1'b1) begin
      n_ferr++;
      last_strobe_edge = cyc + 1;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] b, input realtime bit_ns, input bit stop_bit,
                            input bit expect_it, output int t0);
    t0 = cyc;
    if (expect_it) expect_frame(b, stop_bit, t0);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < W; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic send_spiky(input logic [W-1:0] b, output int t0);
    logic [W+1:0] f;
    f = {1'b1, b, 1'b0};
    t0 = cyc;
    expect_frame(b, 1'b1, t0);
    for (int c = 0; c < (W + 2) * CPB; c++) begin
      rx = f[c / CPB] ^ ((c % CPB) == CPB / 2);
      #(T);
    end
    rx = 1'b1;
  endtask
`endif

  task automatic wait_negedge_at(input int target);
    do @(negedge clock); while (cyc < target);
  endtask

  initial begin
    int t;
    int tr;
    int nv;
    int nf;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_data", data, 8'h00);
    idle(5);

    // clean frame
    send_frame(8'hA5, BIT_NS, 1'b1, 1'b1, t);
    idle(20);
    check("a5_data", data, 8'hA5);
    check("a5_count", n_valid, 1);
    check("a5_latency", last_strobe_edge - t, LAT_LITERAL);

    // back-to-back, single stop bit
    send_frame(8'h00, BIT_NS, 1'b1, 1'b1, t);
    send_frame(8'hFF, BIT_NS, 1'b1, 1'b1, t);
    send_frame(8'h55, BIT_NS, 1'b1, 1'b1, t);
    idle(20);
    check("b2b_count", n_valid, 4);
    check("b2b_data", data, 8'h55);

    // 5-cycle glitch
    nv = n_valid;
    t = cyc;
    rx = 1'b0;
    #(5 * T);
    rx = 1'b1;
    wait_negedge_at(t + 3);
    check("glitch_busy_rise", busy, 1'b1);
    wait_negedge_at(t + GLITCH_DONE);
    check("glitch_busy_fall", busy, 1'b0);
    idle(30);
    check("glitch_no_valid", n_valid, nv);
    check("glitch_no_ferr", n_ferr, 0);

    // bad stop bit, line held low 40 bit times
    send_frame(8'h3C, BIT_NS, 1'b0, 1'b1, t);
    #(40.0 * BIT_NS);
    rx = 1'b1;
    idle(40);
    check("break_ferr_count", n_ferr, 1);
    check("break_data_kept", data, 8'h55);
    check("break_busy", busy, 1'b0);
    send_frame(8'h81, BIT_NS, 1'b1, 1'b1, t);
    idle(20);
    check("after_break_data", data, 8'h81);

    // reset during data bit 4
    nv = n_valid;
    nf = n_ferr;
    tr = cyc;
    fork
      send_frame(8'hF0, BIT_NS, 1'b1, 1'b0, t);
      begin
        while (cyc < tr + 16 * 5 + 8) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", data, 8'h00);
        check("midrst_valid", valid, 1'b0);
        check("midrst_ferr", frame_error, 1'b0);
        reset = 1'b0;
      end
    join
    idle(100);
    check("midrst_no_valid", n_valid, nv);
    check("midrst_no_ferr", n_ferr, nf);
    send_frame(8'h12, BIT_NS, 1'b1, 1'b1, t);
    idle(20);
    check("after_rst_data", data, 8'h12);

    // baud skew
    send_frame(8'h69, SLOW_NS, 1'b1, 1'b1, t);
    idle(20);
    check("skew_slow_data", data, 8'h69);
    send_frame(8'h96, BIT_NS, 1'b1, 1'b1, t);
    idle(20);
    send_frame(8'h69, FAST_NS, 1'b1, 1'b1, t);
    idle(20);
    check("skew_fast_data", data, 8'h69);
    check("skew_no_ferr", n_ferr, 1);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h00, BIT_NS, 1'b1, 1'b1, t);
    idle(5);
    send_spiky(8'h69, t);
    idle(20);
    check("spike_data", data, 8'h69);
    check("spike_no_ferr", n_ferr, 1);
`endif

    idle(10);
    check("exp_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sync.md
# uart_rx_sync

8N1 UART receiver: the receive half of the board's serial link, paired with the 8N1 transmitter on the same `UART_config.sv` baud and width settings. Brings the asynchronous `rx` line into the `clock` domain, finds the start bit, samples each data bit at mid-bit, checks the stop bit, and presents each byte with a one-cycle `valid` strobe. It sits between the board RX pin and the command decoder, with no buffering: the consumer must take each byte on its strobe.

## Interface
- `WIDTH`, default `` `WIDTH `` (8): data bits per frame, sent LSB first.
- `CLOCKS_PER_BIT`, default `` `CLK_FREQ / `BAUD_RATE ``: clock cycles per bit; must be at least 4.
- `clock`  in  1  the only clock.
- `reset`  in  1  synchronous, active-high.
- `rx`  in  1  asynchronous serial line; idles high.
- `data`  out  `WIDTH`  last received byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse when `data` updates.
- `frame_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high from start-bit detect until return to IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer and then one history register. A falling edge is seen when the history register is 1 and the synchronized value is 0.
- Baud counter: width `$clog2(CLOCKS_PER_BIT)`. It is reloaded on each state entry and counts down.
- Bit counter: width `$clog2(WIDTH)+1`.
- States:
  - IDLE: on a falling edge, go to START and load `CLOCKS_PER_BIT/2 - 1`.
  - START: when the counter reaches 0, sample the line. If the sample is 1 (glitch), go to IDLE with no pulse. If 0, go to DATA and load `CLOCKS_PER_BIT - 1`.
  - DATA: each time the counter reaches 0, shift the sample into the MSB of the shift register (LSB-first reception) and reload. After `WIDTH` samples, go to STOP.
  - STOP: when the counter reaches 0, sample the line. If 1, copy the shift register to `data`, pulse `valid`, and go to IDLE. If 0, pulse `frame_error`, leave `data` unchanged, and go to BREAK.
  - BREAK: wait until the synchronized `rx` is 1, then go to IDLE. A held-low line produces exactly one `frame_error`.
- `valid` and `frame_error` never assert in the same cycle.
- Reset values: `data` = 0, `valid` = 0, `frame_error` = 0, `busy` = 0, state = IDLE, history register = 1, synchronizer = 1.
- `reset` mid-frame aborts with no pulse. The next falling edge after reset starts a new frame.

## Timing
- The falling edge is seen 3 cycles after the `rx` pin falls (2 sync flops plus the history register).
- Sample points fall at mid-bit: start at +`CLOCKS_PER_BIT/2`, data bit k at +`(k+1)*CLOCKS_PER_BIT + CLOCKS_PER_BIT/2`, stop at +`(WIDTH+1)*CLOCKS_PER_BIT + CLOCKS_PER_BIT/2` (all from edge detect).
- `valid` / `frame_error` are registered and assert on the cycle after the stop sample.
- `busy` drops in that same cycle, so IDLE can accept a falling edge on the very next cycle. Back-to-back frames with a single stop bit are received without loss.
- Allowed baud mismatch: ±4% for `WIDTH` = 8.

## Configuration
- `UART_RX_MAJORITY_EN` defined: every sample is the 2-of-3 majority of the synchronized line at counter values 1, 0 and `CLOCKS_PER_BIT-1` (the cycle after reload). The decision is taken one cycle after the nominal point. All state transitions, and `valid`/`frame_error`, shift one cycle later.
- Undefined: a single sample at counter value 0, with no extra latency.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - `CLOCKS_PER_BIT` and `HALF_BIT` localparams derived from the `UART_config.sv` macros;
  - the counter width functions.
- Sub-module `uart_sync_2ff`: the 2-flop synchronizer with reset value 1. It is reused for other asynchronous board inputs.
- Everything else lives in one FSM module.

## Test plan
Bench overrides `CLOCKS_PER_BIT` = 16, `WIDTH` = 8.
- Clean frame 0xA5 with an ideal transmitter -> `valid` pulses once, `data` = 0xA5, `frame_error` = 0. The pulse comes 3 + 8 + 144 + 1 cycles after the falling edge of the start bit (+1 with majority).
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three `valid` pulses, data 0x00, 0xFF, 0x55, in order.
- 5-cycle low glitch on idle `rx` -> no `valid`, no `frame_error`. `busy` rises, then returns to 0 within 9 cycles of detect.
- Frame 0x3C with the stop bit driven low, then `rx` held low for 40 bit times -> exactly one `frame_error` pulse and `data` keeps its old value. After `rx` returns high, the next frame 0x81 is received correctly.
- `reset` asserted during data bit 4 of frame 0xF0 -> all outputs 0 the next cycle and no pulse for that frame. The following frame 0x12 is received.
- Baud skew of +4% and -4% (bit periods of 16.64 / 15.36 cycles) on frame 0x69 -> `data` = 0x69 with no error. With majority enabled: single-cycle inverted spikes at each mid-bit point are also rejected.
